// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and the RV32I opcode constants also used by the control unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INST  = 32'h0000_0013;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch: one outstanding imem request, one held instruction,
// redirects from execute squash wrong-path fetches.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [6:0]      opcode,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target
);

   localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INST);

   fetch_state_t    state, state_next;
   logic [XLEN-1:0] pc, pc_next;
   logic            discard, discard_next;
   logic [XLEN-1:0] inst_q, inst_next;
   logic [XLEN-1:0] inst_pc_q, inst_pc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         discard   <= 1'b0;
         inst_q    <= NOP;
         inst_pc_q <= RESET_PC;
      end else begin
         state     <= state_next;
         pc        <= pc_next;
         discard   <= discard_next;
         inst_q    <= inst_next;
         inst_pc_q <= inst_pc_next;
      end
   end

   always_comb begin
      state_next   = state;
      pc_next      = pc;
      discard_next = discard;
      inst_next    = inst_q;
      inst_pc_next = inst_pc_q;
      case (state)
         IDLE:  state_next = FETCH;
         FETCH: begin
            if (imem_req_ready) begin
               state_next   = WAIT;
               discard_next = redirect_valid;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               // A squashed or same-cycle-redirected response just returns to FETCH.
               state_next   = FETCH;
               discard_next = 1'b0;
               if (!discard && !redirect_valid) begin
                  state_next   = HOLD;
                  inst_next    = imem_rsp_data;
                  inst_pc_next = pc;
                  pc_next      = pc + XLEN'(4);
               end
            end else if (redirect_valid) begin
               discard_next = 1'b1;
            end
         end
         HOLD: begin
            if (inst_ready || redirect_valid) begin
               state_next = FETCH;
               inst_next  = NOP;
            end
         end
         default: state_next = IDLE;
      endcase
      if (redirect_valid && state != IDLE)
         pc_next = {redirect_target[XLEN-1:2], 2'b00};
   end

   assign imem_req_valid = (state == FETCH);
   assign imem_req_addr  = pc;
   assign inst_valid     = (state == HOLD);
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
   assign opcode         = inst_q[6:0];

   // Memory only ever answers an accepted request, so a response elsewhere is a protocol bug.
   rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (state == WAIT));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table for the documented corner cases, then randomized traffic against
// a transaction-level model of the fetch stream.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data;
   logic        inst_valid, inst_ready, redirect_valid;
   logic [31:0] inst, inst_pc, redirect_target;
   logic [6:0]  opcode;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0013_5A5A;
   endfunction

   typedef struct {
      logic rst, rr, rv; logic [31:0] rd; logic ir, xv; logic [31:0] xt;
      logic chk, e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_inst, e_pc; logic cpc;
   } vec_t;

   function automatic vec_t v(input logic rst_i, rr, rv, input logic [31:0] rd, input logic ir, xv,
                              input logic [31:0] xt, input logic c, erv, input logic [31:0] eaddr,
                              input logic eiv, input logic [31:0] einst, epc, input logic cpc);
      vec_t r;
      r.rst = rst_i; r.rr = rr; r.rv = rv; r.rd = rd; r.ir = ir; r.xv = xv; r.xt = xt;
      r.chk = c; r.e_rv = erv; r.e_addr = eaddr; r.e_iv = eiv; r.e_inst = einst; r.e_pc = epc;
      r.cpc = cpc;
      return r;
   endfunction

   vec_t tbl[$];

   // random-phase model state
   logic [31:0] m_pc, m_addr, h_pc, mem_addr, exp_inst;
   logic        m_out, m_live, m_held, mem_busy, acc, hs;
   int unsigned dly;
   int          age, hs_cnt;

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      inst_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

      //          rst rr rv rd            ir xv xt            chk erv addr          iv inst         pc            cpc
      tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,            0, 0, 0,            0, NOP,         0,            0));
      tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,            1, 0, 0,            0, NOP,         0,            1));
      tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,            1, 0, 0,            0, NOP,         0,            1));
      tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,            1, 1, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 1, 32'h33,       0, 0, 0,            1, 0, 0,            0, NOP,         0,            0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(v(0, 0, 0, 0,         0, 0, 0,            1, 0, 0,            1, 32'h33,      0,            1));
      tbl.push_back(v(0, 0, 0, 0,            1, 0, 0,            1, 0, 0,            1, 32'h33,      0,            1));
      tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,            1, 1, 4,            0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 0, 0,            0, 1, 32'h100,      1, 0, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,            1, 0, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 1, 32'h6F,       0, 0, 0,            1, 0, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,            1, 1, 32'h100,      0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 1, 32'h3,        0, 0, 0,            1, 0, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 0, 0,            1, 1, 32'h203,      1, 0, 0,            1, 32'h3,       32'h100,      1));
      for (int i = 0; i < 3; i++)
         tbl.push_back(v(0, 0, 0, 0,         0, 0, 0,            1, 1, 32'h200,      0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 0, 0,            0, 1, 32'h40,       1, 1, 32'h200,      0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,            1, 1, 32'h40,       0, NOP,         0,            0));
      tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,            1, 1, 32'h40,       0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 1, 32'h6F,       0, 1, 32'hFFFF_FFFC, 1, 0, 0,           0, NOP,         0,            0));
      tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,            1, 1, 32'hFFFF_FFFC, 0, NOP,        0,            0));
      tbl.push_back(v(0, 0, 1, 32'h63,       0, 0, 0,            1, 0, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 0, 0,            1, 0, 0,            1, 0, 0,            1, 32'h63,      32'hFFFF_FFFC, 1));
      tbl.push_back(v(0, 1, 0, 0,            0, 0, 0,            1, 1, 0,            0, NOP,         0,            0));
      tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,            1, 0, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,            1, 0, 0,            0, NOP,         0,            1));
      tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,            1, 1, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 1, 0, 0,            0, 1, 32'h80,       1, 1, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 1, 32'h33,       0, 0, 0,            1, 0, 0,            0, NOP,         0,            0));
      tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,            1, 1, 32'h80,       0, NOP,         0,            0));

      foreach (tbl[i]) begin
         @(negedge clk);
         if (tbl[i].chk) begin
            check($sformatf("v%0d.req_valid", i), imem_req_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) check($sformatf("v%0d.req_addr", i), imem_req_addr, tbl[i].e_addr);
            check($sformatf("v%0d.inst_valid", i), inst_valid, tbl[i].e_iv);
            check($sformatf("v%0d.inst", i), inst, tbl[i].e_inst);
            check($sformatf("v%0d.opcode", i), opcode, tbl[i].e_inst[6:0]);
            if (tbl[i].cpc) check($sformatf("v%0d.inst_pc", i), inst_pc, tbl[i].e_pc);
         end
         rst = tbl[i].rst; imem_req_ready = tbl[i].rr; imem_rsp_valid = tbl[i].rv;
         imem_rsp_data = tbl[i].rd; inst_ready = tbl[i].ir;
         redirect_valid = tbl[i].xv; redirect_target = tbl[i].xt;
      end

      // Randomized phase: fresh reset, then model tracks the architectural fetch stream.
      @(negedge clk);
      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_pc = 32'h0; m_out = 1'b0; m_live = 1'b0; m_held = 1'b0; m_addr = '0; h_pc = '0;
      mem_busy = 1'b0; mem_addr = '0; dly = 0; age = 0; hs_cnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         exp_inst = m_held ? mem_word(h_pc) : NOP;
         check("rnd.inst_valid", inst_valid, m_held);
         check("rnd.inst", inst, exp_inst);
         check("rnd.opcode", opcode, exp_inst[6:0]);
         if (m_held) check("rnd.inst_pc", inst_pc, h_pc);
         if (imem_req_valid) begin
            check("rnd.req_addr", imem_req_addr, m_pc);
            check("rnd.req_while_busy", {m_out, m_held}, 0);
         end

         imem_req_ready  = ($urandom_range(0, 3) != 0);
         inst_ready      = ($urandom_range(0, 2) != 0);
         redirect_valid  = (age > 2) && ($urandom_range(0, 9) == 0);
         redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
         if (mem_busy && dly == 0) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mem_addr);
         end else begin
            imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
         end

         acc = imem_req_valid && imem_req_ready;
         hs  = inst_valid && inst_ready;
         if (imem_rsp_valid) mem_busy = 1'b0;
         else if (mem_busy && dly > 0) dly--;
         if (acc) begin
            mem_busy = 1'b1; mem_addr = imem_req_addr; dly = $urandom_range(0, 2);
         end

         if (imem_rsp_valid) begin
            m_out = 1'b0;
            if (m_live && !redirect_valid) begin
               m_held = 1'b1; h_pc = m_addr; m_pc = m_addr + 32'd4;
            end
         end
         if (acc) begin
            m_out = 1'b1; m_live = !redirect_valid; m_addr = m_pc;
         end
         if (hs) hs_cnt++;
         if (hs && !redirect_valid) m_held = 1'b0;
         if (redirect_valid) begin
            m_pc = {redirect_target[31:2], 2'b00}; m_live = 1'b0; m_held = 1'b0;
         end
         age++;
      end
      @(negedge clk);
      redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
      check("rnd.progress", 32'(hs_cnt >= 100), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
